// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared constants and types for the registered full adder
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  // Wide enough for {carry_out, sum} at the largest legal WIDTH.
  typedef logic [FA_MAX_WIDTH:0] fa_result_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry adder with registered sum, carry and valid
module full_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_out_d, c_out_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .cout(carry[i+1])
    );
  end

  // Operands are ignored when in_valid is low so don't-care inputs never reach the held result.
  always_comb begin
    s_d         = s_q;
    c_out_d     = c_out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d     = sum;
      c_out_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed and random checks of full_adder at WIDTH 1, 4 and 8
module tb_full_adder;
  import fa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1;
  logic       iv4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4;
  logic       co4, ov4;
  logic       iv8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8;
  logic       co8, ov8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
    .s(s1), .c_out(co1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(4)) u_fa4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .c(c4),
    .s(s4), .c_out(co4), .out_valid(ov4)
  );
  full_adder #(.WIDTH(8)) u_fa8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .c(c8),
    .s(s8), .c_out(co8), .out_valid(ov8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  tbl_s;
    logic [7:0]  tbl_co;
    logic [7:0]  exp_s8;
    logic        exp_co8;
    logic        exp_ov8;
    fa_result_t  r;

    // Reset with a live transaction on every instance: it must be dropped.
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step();
    chk("rst_s1", 65'(s1), 65'd0);
    chk("rst_co1", 65'(co1), 65'd0);
    chk("rst_ov1", 65'(ov1), 65'd0);
    chk("rst_s4", 65'(s4), 65'd0);
    chk("rst_ov4", 65'(ov4), 65'd0);
    chk("rst_ov8", 65'(ov8), 65'd0);

    rst = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
    step();
    chk("post_rst_idle_ov1", 65'(ov1), 65'd0);
    chk("post_rst_idle_s1", 65'(s1), 65'd0);

    // Exhaustive WIDTH=1, index = {a,b,c}.
    tbl_s  = 8'b1001_0110;
    tbl_co = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      iv1 = 1'b1; a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
      step();
      chk($sformatf("w1_s_%0d", i), 65'(s1), 65'(tbl_s[i]));
      chk($sformatf("w1_co_%0d", i), 65'(co1), 65'(tbl_co[i]));
      chk($sformatf("w1_ov_%0d", i), 65'(ov1), 65'd1);
    end

    // Hold: load 1+0+0, then idle with all-ones operands.
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    step();
    chk("hold_load_s", 65'(s1), 65'd1);
    chk("hold_load_co", 65'(co1), 65'd0);
    iv1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_s_%0d", i), 65'(s1), 65'd1);
      chk($sformatf("hold_co_%0d", i), 65'(co1), 65'd0);
      chk($sformatf("hold_ov_%0d", i), 65'(ov1), 65'd0);
    end

    // WIDTH=4 wrap-around and all-ones boundaries.
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
    step();
    chk("wrap_s", 65'(s4), 65'h0);
    chk("wrap_co", 65'(co4), 65'd1);
    chk("wrap_ov", 65'(ov4), 65'd1);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    step();
    chk("ones_s", 65'(s4), 65'hF);
    chk("ones_co", 65'(co4), 65'd1);

    // Back-to-back WIDTH=4.
    a4 = 4'd3; b4 = 4'd4; c4 = 1'b0;
    step();
    chk("b2b0_s", 65'(s4), 65'd7);
    chk("b2b0_co", 65'(co4), 65'd0);
    chk("b2b0_ov", 65'(ov4), 65'd1);
    a4 = 4'd8; b4 = 4'd8; c4 = 1'b1;
    step();
    chk("b2b1_s", 65'(s4), 65'd1);
    chk("b2b1_co", 65'(co4), 65'd1);
    chk("b2b1_ov", 65'(ov4), 65'd1);

    // Reset mid-stream with in_valid held high, then release.
    rst = 1'b1; a4 = 4'd5; b4 = 4'd6; c4 = 1'b0;
    step();
    chk("mid_rst_ov", 65'(ov4), 65'd0);
    chk("mid_rst_s", 65'(s4), 65'd0);
    chk("mid_rst_co", 65'(co4), 65'd0);
    rst = 1'b0;
    step();
    chk("after_rst_ov", 65'(ov4), 65'd1);
    chk("after_rst_s", 65'(s4), 65'd11);
    iv4 = 1'b0;

    // Random WIDTH=8 against an unsigned addition model.
    exp_s8 = 8'd0; exp_co8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      iv8 = 1'($urandom_range(0, 3) != 0);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 1'($urandom);
      if (iv8) begin
        r       = fa_result_t'(a8) + fa_result_t'(b8) + fa_result_t'(c8);
        exp_s8  = r[7:0];
        exp_co8 = r[8];
      end
      exp_ov8 = iv8;
      step();
      chk($sformatf("rnd_s_%0d", i), 65'(s8), 65'(exp_s8));
      chk($sformatf("rnd_co_%0d", i), 65'(co8), 65'(exp_co8));
      chk($sformatf("rnd_ov_%0d", i), 65'(ov8), 65'(exp_ov8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
